// File: rtl/pipeline_pkg.sv
// Shared types and opcode decode for the 3-stage pipeline sequencer.
package pipeline_pkg;

    localparam int REG_IDX_W   = 4;
    localparam int FLUSH_CNT_W = 2;

    typedef enum logic [1:0] {
        PS_RUN   = 2'd0,
        PS_STALL = 2'd1,
        PS_FLUSH = 2'd2,
        PS_HALT  = 2'd3
    } t_pipe_state;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_LOADI  = 5'd1;
    localparam logic [4:0] OP_LOAD   = 5'd2;
    localparam logic [4:0] OP_STORE  = 5'd3;
    localparam logic [4:0] OP_ALU    = 5'd4;
    localparam logic [4:0] OP_ALUM   = 5'd5;
    localparam logic [4:0] OP_ALUMI  = 5'd6;
    localparam logic [4:0] OP_JUMP   = 5'd7;
    localparam logic [4:0] OP_BRANCH = 5'd8;
    localparam logic [4:0] OP_HALT   = 5'd9;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
        logic                 uses_a;
        logic                 uses_b;
        logic                 writes_dest;
        logic                 is_halt;
    } t_decode;

    function automatic t_decode decode_instr(input logic [31:0] instr);
        t_decode d;
        d.dest        = instr[23:20];
        d.src_a       = instr[19:16];
        d.src_b       = instr[11:8];
        d.uses_a      = 1'b0;
        d.uses_b      = 1'b0;
        d.writes_dest = 1'b0;
        d.is_halt     = 1'b0;
        case (instr[31:27])
            OP_LOADI: d.writes_dest = 1'b1;
            OP_LOAD: begin
                d.uses_a      = 1'b1;
                d.writes_dest = 1'b1;
            end
            OP_STORE: begin
                d.uses_a = 1'b1;
                d.uses_b = 1'b1;
            end
            OP_ALU: begin
                d.uses_a      = 1'b1;
                d.uses_b      = 1'b1;
                d.writes_dest = 1'b1;
            end
            OP_ALUM, OP_ALUMI: begin
                d.uses_a      = 1'b1;
                d.writes_dest = 1'b1;
            end
            OP_JUMP:  d.uses_a  = 1'b1;
            OP_HALT:  d.is_halt = 1'b1;
            default:  d.is_halt = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Pending-write bit per architectural register with two combinational read ports.
import pipeline_pkg::*;

module pipe_scoreboard #(
    parameter int NUM_REGS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_set_en,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr_en,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    input  logic                 i_clr_all,
    input  logic [REG_IDX_W-1:0] i_rd_idx_a,
    input  logic [REG_IDX_W-1:0] i_rd_idx_b,
    output logic                 o_rd_a,
    output logic                 o_rd_b
);

    logic [NUM_REGS-1:0] r_pending;

    // Set is written after clear so a same-cycle set on the same index wins.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr_all) begin
            r_pending <= '0;
        end else begin
            if (i_clr_en) begin
                r_pending[i_clr_idx] <= 1'b0;
            end
            if (i_set_en) begin
                r_pending[i_set_idx] <= 1'b1;
            end
        end
    end

    assign o_rd_a = r_pending[i_rd_idx_a];
    assign o_rd_b = r_pending[i_rd_idx_b];

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencer: hazard/bus stalls, jump flush, halt latch and stall statistics.
import pipeline_pkg::*;

module pipeline_control #(
    parameter int NUM_REGS    = 16,
    parameter int FLUSH_DEPTH = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [31:0]            fetch_instruction,
    input  logic                   stage2_write,
    input  logic                   stage2_write_immediate,
    input  logic [3:0]             stage2_write_index,
    input  logic                   jump,
    input  logic                   bus_busy,
    output logic                   issue,
    output logic                   stall_fetch,
    output logic                   stall_stage1,
    output logic                   flush_stage0,
    output logic                   flush_stage1,
    output logic                   halted,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    t_pipe_state             r_state;
    logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
    logic [STALL_CNT_W-1:0]  r_stall_cycles;

    t_decode w_dec;
    logic    w_pend_a;
    logic    w_pend_b;
    logic    w_hazard;
    logic    w_halted;
    logic    w_jump;
    logic    w_flush;
    logic    w_stall_fetch;
    logic    w_issue;
    logic    w_halt_req;

    assign w_dec         = decode_instr(fetch_instruction);
    assign w_hazard      = fetch_valid & ((w_dec.uses_a & w_pend_a) | (w_dec.uses_b & w_pend_b));
    assign w_halted      = (r_state == PS_HALT);
    // A halted core ignores jumps entirely.
    assign w_jump        = jump & ~w_halted;
    assign w_flush       = w_jump | (r_state == PS_FLUSH);
    assign w_stall_fetch = w_hazard | bus_busy | w_halted;
    assign w_issue       = fetch_valid & ~w_stall_fetch & ~w_flush;
    assign w_halt_req    = fetch_valid & w_dec.is_halt & ~w_hazard;

    pipe_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_set_en   (w_issue & w_dec.writes_dest),
        .i_set_idx  (w_dec.dest),
        .i_clr_en   (stage2_write | stage2_write_immediate),
        .i_clr_idx  (stage2_write_index),
        .i_clr_all  (w_jump),
        .i_rd_idx_a (w_dec.src_a),
        .i_rd_idx_b (w_dec.src_b),
        .o_rd_a     (w_pend_a),
        .o_rd_b     (w_pend_b)
    );

    // Sequencer state and flush countdown; priority is jump > halt > bus/hazard.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= PS_RUN;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                PS_RUN, PS_STALL: begin
                    if (w_jump) begin
                        r_state     <= (FLUSH_DEPTH > 1) ? PS_FLUSH : PS_RUN;
                        r_flush_cnt <= FLUSH_CNT_W'(FLUSH_DEPTH - 1);
                    end else if (w_halt_req) begin
                        r_state <= PS_HALT;
                    end else if (bus_busy || w_hazard) begin
                        r_state <= PS_STALL;
                    end else begin
                        r_state <= PS_RUN;
                    end
                end
                PS_FLUSH: begin
                    if (w_jump) begin
                        r_state     <= (FLUSH_DEPTH > 1) ? PS_FLUSH : PS_RUN;
                        r_flush_cnt <= FLUSH_CNT_W'(FLUSH_DEPTH - 1);
                    end else if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
                        r_state     <= PS_RUN;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                PS_HALT: begin
                    r_state <= PS_HALT;
                end
                default: begin
                    r_state     <= PS_RUN;
                    r_flush_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of fetch-stalled cycles outside halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall_fetch && !w_halted && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    // Reset forces the control outputs quiet in the reset cycle itself.
    assign issue        = w_issue & ~reset;
    assign stall_fetch  = w_stall_fetch & ~reset;
    assign stall_stage1 = bus_busy & ~reset;
    assign flush_stage0 = w_flush & ~reset;
    assign flush_stage1 = w_flush & ~reset;
    assign halted       = w_halted & ~reset;
    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_pipeline_control;
    import pipeline_pkg::*;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instruction = 32'd0;
    logic        stage2_write = 1'b0;
    logic        stage2_write_immediate = 1'b0;
    logic [3:0]  stage2_write_index = 4'd0;
    logic        jump = 1'b0;
    logic        bus_busy = 1'b0;

    logic        issue, stall_fetch, stall_stage1, flush_stage0, flush_stage1, halted;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic        s_issue, s_stall_fetch, s_stall_stage1, s_flush_stage0, s_flush_stage1, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cycles;

    pipeline_control #(.NUM_REGS(16), .FLUSH_DEPTH(DEPTH), .STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .fetch_instruction(fetch_instruction), .stage2_write(stage2_write),
        .stage2_write_immediate(stage2_write_immediate),
        .stage2_write_index(stage2_write_index), .jump(jump), .bus_busy(bus_busy),
        .issue(issue), .stall_fetch(stall_fetch), .stall_stage1(stall_stage1),
        .flush_stage0(flush_stage0), .flush_stage1(flush_stage1), .halted(halted),
        .state(state), .stall_cycles(stall_cycles));

    pipeline_control #(.NUM_REGS(16), .FLUSH_DEPTH(DEPTH), .STALL_CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .fetch_instruction(fetch_instruction), .stage2_write(stage2_write),
        .stage2_write_immediate(stage2_write_immediate),
        .stage2_write_index(stage2_write_index), .jump(jump), .bus_busy(bus_busy),
        .issue(s_issue), .stall_fetch(s_stall_fetch), .stall_stage1(s_stall_stage1),
        .flush_stage0(s_flush_stage0), .flush_stage1(s_flush_stage1), .halted(s_halted),
        .state(s_state), .stall_cycles(s_stall_cycles));

    always #5 clock = ~clock;

    typedef struct {
        logic        issue, sf, ss1, f0, f1, halted;
        logic [1:0]  st;
        logic [15:0] sc16;
        logic [3:0]  sc4;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: abstract pipeline condition, not the RTL encoding.
    bit pend[16];
    int flush_left  = 0;
    bit m_halted    = 1'b0;
    bit m_stalled   = 1'b0;
    int stall_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue",        32'(issue),          32'(e.issue));
            chk("stall_fetch",  32'(stall_fetch),    32'(e.sf));
            chk("stall_stage1", 32'(stall_stage1),   32'(e.ss1));
            chk("flush_stage0", 32'(flush_stage0),   32'(e.f0));
            chk("flush_stage1", 32'(flush_stage1),   32'(e.f1));
            chk("halted",       32'(halted),         32'(e.halted));
            chk("state",        32'(state),          32'(e.st));
            chk("stall_cycles", 32'(stall_cycles),   32'(e.sc16));
            chk("sat_state",    32'(s_state),        32'(e.st));
            chk("sat_stall_cycles", 32'(s_stall_cycles), 32'(e.sc4));
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input int d, input int a, input int b,
                                       input logic [31:0] noise);
        logic [31:0] r;
        r        = noise;
        r[31:27] = op;
        r[23:20] = 4'(d);
        r[19:16] = 4'(a);
        r[11:8]  = 4'(b);
        return r;
    endfunction

    task automatic step(input bit rst, input bit fv, input logic [31:0] ins, input bit w,
                        input bit wi, input int widx, input bit j, input bit bb);
        exp_t e;
        bit   ua, ub, wd, hl, hz, flushing, sf;
        int   d, a, b;
        @(posedge clock);
        #1;
        reset = rst; fetch_valid = fv; fetch_instruction = ins;
        stage2_write = w; stage2_write_immediate = wi; stage2_write_index = 4'(widx);
        jump = j; bus_busy = bb;

        d = int'(ins[23:20]); a = int'(ins[19:16]); b = int'(ins[11:8]);
        ua = 1'b0; ub = 1'b0; wd = 1'b0; hl = 1'b0;
        case (ins[31:27])
            OP_LOADI:          wd = 1'b1;
            OP_LOAD:           begin ua = 1'b1; wd = 1'b1; end
            OP_STORE:          begin ua = 1'b1; ub = 1'b1; end
            OP_ALU:            begin ua = 1'b1; ub = 1'b1; wd = 1'b1; end
            OP_ALUM, OP_ALUMI: begin ua = 1'b1; wd = 1'b1; end
            OP_JUMP:           ua = 1'b1;
            OP_HALT:           hl = 1'b1;
            default:           hl = 1'b0;
        endcase
        hz = fv && ((ua && pend[a]) || (ub && pend[b]));

        e.st   = m_halted ? 2'(PS_HALT) : (flush_left > 0) ? 2'(PS_FLUSH) :
                 m_stalled ? 2'(PS_STALL) : 2'(PS_RUN);
        e.sc16 = (stall_total > 65535) ? 16'hFFFF : 16'(stall_total);
        e.sc4  = (stall_total > 15) ? 4'hF : 4'(stall_total);
        flushing = !m_halted && (j || flush_left > 0);
        sf       = m_halted || hz || bb;
        if (rst) begin
            e.issue = 0; e.sf = 0; e.ss1 = 0; e.f0 = 0; e.f1 = 0; e.halted = 0;
        end else begin
            e.issue  = fv && !sf && !flushing;
            e.sf     = sf;
            e.ss1    = bb;
            e.f0     = flushing;
            e.f1     = flushing;
            e.halted = m_halted;
        end
        exp_q.push_back(e);

        if (rst) begin
            foreach (pend[i]) pend[i] = 1'b0;
            flush_left = 0; m_halted = 1'b0; m_stalled = 1'b0; stall_total = 0;
        end else if (m_halted) begin
            if (w || wi) pend[widx] = 1'b0;
        end else begin
            if (sf) stall_total++;
            if (j) begin
                foreach (pend[i]) pend[i] = 1'b0;
                flush_left = DEPTH - 1;
                m_stalled  = 1'b0;
            end else begin
                if (w || wi) pend[widx] = 1'b0;
                if (e.issue && wd) pend[d] = 1'b1;
                if (flush_left > 0) begin
                    flush_left--;
                    m_stalled = 1'b0;
                end else if (fv && hl && !hz) begin
                    m_halted  = 1'b1;
                    m_stalled = 1'b0;
                end else begin
                    m_stalled = bb || hz;
                end
            end
        end
    endtask

    initial begin
        logic [4:0] op;
        int r;
        foreach (pend[i]) pend[i] = 1'b0;
        repeat (2) @(posedge clock);
        step(1, 0, 32'd0, 0, 0, 0, 0, 0);
        step(1, 1, mk(OP_ALU, 3, 1, 2, 32'd0), 1, 0, 3, 1, 1);

        // RAW on r3, cleared by stage2 after a few cycles (bypass still stalls)
        step(0, 1, mk(OP_ALU, 3, 1, 2, 32'd0), 0, 0, 0, 0, 0);
        repeat (4) step(0, 1, mk(OP_ALU, 4, 3, 0, 32'd0), 0, 0, 0, 0, 0);
        step(0, 1, mk(OP_ALU, 4, 3, 0, 32'd0), 1, 0, 3, 0, 0);
        step(0, 1, mk(OP_ALU, 4, 3, 0, 32'd0), 0, 0, 0, 0, 0);
        step(0, 1, mk(OP_NOP, 0, 0, 0, 32'd0), 1, 0, 4, 0, 0);

        // Same-cycle set and clear of r5: set must win
        step(0, 1, mk(OP_LOADI, 5, 0, 0, 32'd0), 0, 1, 5, 0, 0);
        repeat (2) step(0, 1, mk(OP_STORE, 0, 0, 5, 32'd0), 0, 0, 0, 0, 0);

        // Jump flush clears the scoreboard, then r5 reads freely
        step(0, 1, mk(OP_STORE, 0, 0, 5, 32'd0), 0, 0, 0, 1, 0);
        repeat (3) step(0, 1, mk(OP_STORE, 0, 5, 5, 32'd0), 0, 0, 0, 0, 0);

        // Bus wait coinciding with jump
        step(0, 1, mk(OP_LOADI, 6, 0, 0, 32'd0), 0, 0, 0, 0, 1);
        step(0, 1, mk(OP_LOADI, 6, 0, 0, 32'd0), 0, 0, 0, 1, 1);
        step(0, 1, mk(OP_LOADI, 6, 0, 0, 32'd0), 0, 0, 0, 0, 1);
        step(0, 1, mk(OP_LOADI, 6, 0, 0, 32'd0), 0, 0, 0, 0, 0);

        // Long hazard on r7 saturates the 4-bit counter
        step(0, 1, mk(OP_ALUMI, 7, 0, 0, 32'd0), 0, 0, 0, 0, 0);
        repeat (20) step(0, 1, mk(OP_ALUM, 8, 7, 0, 32'd0), 0, 0, 0, 0, 0);
        step(0, 1, mk(OP_ALUM, 8, 7, 0, 32'd0), 1, 0, 7, 0, 0);

        // Halt is absorbing, ignores jump, still clears pending writes; reset recovers
        step(0, 1, mk(OP_HALT, 0, 0, 0, 32'd0), 0, 0, 0, 0, 0);
        step(0, 1, mk(OP_LOADI, 9, 0, 0, 32'd0), 0, 1, 8, 1, 0);
        repeat (3) step(0, 1, mk(OP_LOADI, 9, 0, 0, 32'd0), 0, 0, 0, 0, 1);
        step(1, 1, mk(OP_LOADI, 9, 0, 0, 32'd0), 0, 0, 0, 0, 0);
        step(0, 0, 32'd0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 10))
                0: op = OP_LOADI;  1: op = OP_LOAD;   2: op = OP_STORE;
                3: op = OP_ALU;    4: op = OP_ALU;    5: op = OP_ALUM;
                6: op = OP_ALUMI;  7: op = OP_JUMP;   8: op = OP_BRANCH;
                9: op = OP_NOP;    default: op = 5'd20;
            endcase
            if (r < 2) op = OP_HALT;
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 80),
                 mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), $urandom),
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                 int'($urandom_range(0, 4)),
                 ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20));
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
